// File: rtl/frame_ring_buffer.sv
// frame_ring_buffer: NUM_BANKS-deep ring of DEPTH-sample frame banks.
// Samples are written on a valid/ready port. Each full bank is committed as a
// frame, and committed frames are replayed in order with last-word marking.
// Optional feature: define FRAME_RING_DROP_COUNT_EN to enable the saturating
// refused-write counter on drop_count_o. When undefined, drop_count_o is 0.
module frame_ring_buffer #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 16,
    parameter int NUM_BANKS  = 2,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int BANK_WIDTH = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [WIDTH-1:0]        write_data_i,
    input  logic                    write_valid_i,
    output logic                    write_ready_o,
    output logic [WIDTH-1:0]        read_data_o,
    output logic                    read_valid_o,
    input  logic                    read_ready_i,
    output logic                    read_last_o,
    output logic                    frame_ready_o,
    output logic                    overflow_o,
    output logic [BANK_WIDTH:0]     banks_full_o,
    output logic [15:0]             drop_count_o
);

    localparam int CNT_W = BANK_WIDTH + 1;
    localparam logic [CNT_W-1:0] NB = CNT_W'(NUM_BANKS);

    function automatic logic [BANK_WIDTH-1:0] bank_inc(input logic [BANK_WIDTH-1:0] b);
        if (b == BANK_WIDTH'(NUM_BANKS - 1)) return '0;
        return b + BANK_WIDTH'(1);
    endfunction

    logic [WIDTH-1:0]      mem [NUM_BANKS*DEPTH];

    logic [BANK_WIDTH-1:0] rd_bank;      // oldest committed bank, freed by last handshake
    logic [BANK_WIDTH-1:0] iss_bank;     // bank currently being fetched from RAM
    logic [CNT_W-1:0]      full_count;   // committed, not-yet-freed banks
    logic [CNT_W-1:0]      iss_ahead;    // committed banks fully fetched but not yet freed
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;

    logic [WIDTH-1:0]      ram_q;
    logic                  ram_last;
    logic                  ram_v;

    logic [1:0][WIDTH-1:0] skid_data, skid_data_n;
    logic [1:0]            skid_last, skid_last_n;
    logic [1:0]            skid_cnt, skid_cnt_n;

    logic [CNT_W-1:0]      wr_sum;
    logic [BANK_WIDTH-1:0] wr_bank;
    logic                  wr_fire, wr_commit;
    logic [1:0]            occ;
    logic                  issue, iss_done;
    logic [WIDTH-1:0]      head_data;
    logic                  head_last;
    logic                  pop, free;

    assign wr_sum  = {1'b0, rd_bank} + full_count;
    assign wr_bank = (wr_sum >= NB) ? BANK_WIDTH'(wr_sum - NB) : BANK_WIDTH'(wr_sum);

    assign write_ready_o = (full_count < NB) && !rst_i;
    assign overflow_o    = write_valid_i && !write_ready_o && !rst_i;
    assign wr_fire       = write_valid_i && write_ready_o;
    assign wr_commit     = wr_fire && (wr_addr == '1);

    // In-flight RAM read counts as occupied so the skid can never overflow.
    assign occ      = skid_cnt + {1'b0, ram_v};
    assign issue    = !rst_i && (iss_ahead < full_count) && (occ < 2'd2);
    assign iss_done = issue && (rd_addr == '1);

    assign head_data    = (skid_cnt != 2'd0) ? skid_data[0] : ram_q;
    assign head_last    = (skid_cnt != 2'd0) ? skid_last[0] : ram_last;
    assign read_valid_o = !rst_i && ((skid_cnt != 2'd0) || ram_v);
    assign read_data_o  = read_valid_o ? head_data : '0;
    assign read_last_o  = read_valid_o && head_last;
    assign pop          = read_valid_o && read_ready_i;
    assign free         = pop && head_last;
    assign banks_full_o = full_count;

    // Skid next-state: pop the head, then append a RAM word not consumed directly
    always_comb begin
        skid_cnt_n  = skid_cnt;
        skid_data_n = skid_data;
        skid_last_n = skid_last;
        if (pop && skid_cnt != 2'd0) begin
            skid_data_n[0] = skid_data[1];
            skid_last_n[0] = skid_last[1];
            skid_cnt_n     = skid_cnt - 2'd1;
        end
        if (ram_v && !(pop && skid_cnt == 2'd0)) begin
            skid_data_n[skid_cnt_n[0]] = ram_q;
            skid_last_n[skid_cnt_n[0]] = ram_last;
            skid_cnt_n                 = skid_cnt_n + 2'd1;
        end
    end

    // Frame RAM: write port for the writer bank, registered read for the fetcher
    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem[{wr_bank, wr_addr}] <= write_data_i;
        end
        if (issue) begin
            ram_q    <= mem[{iss_bank, rd_addr}];
            ram_last <= (rd_addr == '1);
        end
    end

    // Ring pointers, bank accounting, skid state and commit pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_bank       <= '0;
            iss_bank      <= '0;
            full_count    <= '0;
            iss_ahead     <= '0;
            wr_addr       <= '0;
            rd_addr       <= '0;
            ram_v         <= 1'b0;
            skid_cnt      <= '0;
            skid_data     <= '0;
            skid_last     <= '0;
            frame_ready_o <= 1'b0;
        end else begin
            if (wr_fire) wr_addr <= wr_addr + ADDR_WIDTH'(1);
            if (issue)   rd_addr <= rd_addr + ADDR_WIDTH'(1);
            if (iss_done) iss_bank <= bank_inc(iss_bank);
            if (free)     rd_bank  <= bank_inc(rd_bank);

            case ({wr_commit, free})
                2'b10:   full_count <= full_count + CNT_W'(1);
                2'b01:   full_count <= full_count - CNT_W'(1);
                default: full_count <= full_count;
            endcase
            case ({iss_done, free})
                2'b10:   iss_ahead <= iss_ahead + CNT_W'(1);
                2'b01:   iss_ahead <= iss_ahead - CNT_W'(1);
                default: iss_ahead <= iss_ahead;
            endcase

            ram_v         <= issue;
            skid_cnt      <= skid_cnt_n;
            skid_data     <= skid_data_n;
            skid_last     <= skid_last_n;
            frame_ready_o <= wr_commit;
        end
    end

`ifdef FRAME_RING_DROP_COUNT_EN
    logic [15:0] drop_cnt;

    // Saturating count of refused write attempts
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt <= '0;
        end else if (overflow_o && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign drop_count_o = drop_cnt;
`else
    assign drop_count_o = '0;
`endif

endmodule

// File: tb/tb_frame_ring_buffer.sv
// Scoreboard bench for frame_ring_buffer (NUM_BANKS=3, DEPTH=16, WIDTH=32).
module tb_frame_ring_buffer;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int NB = 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [W-1:0]  write_data_i;
    logic          write_valid_i;
    logic          write_ready_o;
    logic [W-1:0]  read_data_o;
    logic          read_valid_o;
    logic          read_ready_i;
    logic          read_last_o;
    logic          frame_ready_o;
    logic          overflow_o;
    logic [2:0]    banks_full_o;
    logic [15:0]   drop_count_o;

    frame_ring_buffer #(.WIDTH(W), .DEPTH(D), .NUM_BANKS(NB)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .write_data_i  (write_data_i),
        .write_valid_i (write_valid_i),
        .write_ready_o (write_ready_o),
        .read_data_o   (read_data_o),
        .read_valid_o  (read_valid_o),
        .read_ready_i  (read_ready_i),
        .read_last_o   (read_last_o),
        .frame_ready_o (frame_ready_o),
        .overflow_o    (overflow_o),
        .banks_full_o  (banks_full_o),
        .drop_count_o  (drop_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } ent_t;

    ent_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         exp_full = 0;
    int         exp_drop = 0;
    int         wr_idx   = 0;
    logic       fr_exp   = 1'b0;
    logic       held     = 1'b0;
    logic [W-1:0] held_data;
    logic       held_last;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Reference model and scoreboard, sampled mid-cycle
    always @(negedge clk_i) begin
        if (rst_i) begin
            check_eq("rst_wready", write_ready_o, 0);
            check_eq("rst_rvalid", read_valid_o, 0);
            check_eq("rst_rdata", read_data_o, 0);
            check_eq("rst_rlast", read_last_o, 0);
            check_eq("rst_overflow", overflow_o, 0);
            sb.delete();
            exp_full = 0;
            exp_drop = 0;
            wr_idx   = 0;
            fr_exp   = 1'b0;
            held     = 1'b0;
        end else begin
            int   commit;
            int   freed;
            ent_t e;
            commit = 0;
            freed  = 0;
            check_eq("banks_full", banks_full_o, exp_full);
            check_eq("wready", write_ready_o, exp_full < NB);
            check_eq("overflow", overflow_o, write_valid_i && exp_full == NB);
            check_eq("frame_ready", frame_ready_o, fr_exp);
            check_eq("drop_count", drop_count_o, exp_drop);
            if (!read_valid_o) begin
                check_eq("rdata_idle", read_data_o, 0);
                check_eq("rlast_idle", read_last_o, 0);
            end
            if (held) begin
                check_eq("stall_valid", read_valid_o, 1);
                check_eq("stall_data", read_data_o, held_data);
                check_eq("stall_last", read_last_o, held_last);
            end

            fr_exp = 1'b0;
            if (write_valid_i && exp_full < NB) begin
                sb.push_back('{d: write_data_i, l: (wr_idx == D-1)});
                if (wr_idx == D-1) begin
                    commit = 1;
                    fr_exp = 1'b1;
                end
                wr_idx = (wr_idx + 1) % D;
            end
`ifdef FRAME_RING_DROP_COUNT_EN
            if (write_valid_i && exp_full == NB && exp_drop < 16'hFFFF) exp_drop++;
`endif
            if (read_valid_o && read_ready_i) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("rdata", read_data_o, e.d);
                    check_eq("rlast", read_last_o, e.l);
                    if (e.l) freed = 1;
                end
            end
            held      = read_valid_o && !read_ready_i;
            held_data = read_data_o;
            held_last = read_last_o;
            exp_full  = exp_full + commit - freed;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] pat [96];

    initial begin
        int acc;
        int ovf;
        logic found;

        rst_i = 1'b1; write_valid_i = 1'b0; write_data_i = '0; read_ready_i = 1'b0;
        repeat (3) tick;
        rst_i = 1'b0;

        // Single frame, reader idle: commit pulse at T+1, first word at T+2
        read_ready_i = 1'b1;
        for (int i = 0; i < D; i++) begin
            write_valid_i = 1'b1;
            write_data_i  = W'(i);
            tick;
        end
        write_valid_i = 1'b0;
        @(negedge clk_i); check_eq("lat_t1_novalid", read_valid_o, 0);
        check_eq("lat_t1_frame", frame_ready_o, 1);
        @(negedge clk_i); check_eq("lat_t2_valid", read_valid_o, 1);
        for (int i = 1; i < D; i++) begin
            @(negedge clk_i); check_eq("run_valid", read_valid_o, 1);
        end
        @(negedge clk_i); check_eq("run_end", read_valid_o, 0);
        tick;

        // Fill all three banks with the reader stalled, then refuse 5 writes
        rst_i = 1'b1; tick; tick; rst_i = 1'b0;
        read_ready_i = 1'b0;
        for (int i = 0; i < NB*D; i++) begin
            write_valid_i = 1'b1;
            write_data_i  = W'(1000 + i);
            tick;
        end
        write_valid_i = 1'b0;
        @(negedge clk_i);
        check_eq("full_banks", banks_full_o, 3);
        check_eq("full_wready", write_ready_o, 0);
        tick;
        ovf = 0;
        for (int k = 0; k < 5; k++) begin
            write_valid_i = 1'b1;
            write_data_i  = W'(5000 + k);
            @(negedge clk_i);
            if (overflow_o) ovf++;
            tick;
        end
        write_valid_i = 1'b0;
        check_eq("ovf_pulses", ovf, 5);
        @(negedge clk_i);
`ifdef FRAME_RING_DROP_COUNT_EN
        check_eq("drop_5", drop_count_o, 5);
`else
        check_eq("drop_off", drop_count_o, 0);
`endif
        tick;

        // Drain one frame: writer regains a bank the cycle after the last handshake
        read_ready_i = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 64 && !found; c++) begin
            @(negedge clk_i);
            if (read_valid_o && read_ready_i && read_last_o) found = 1'b1;
        end
        check_eq("free_seen", found, 1);
        tick;
        read_ready_i = 1'b0;
        @(negedge clk_i); check_eq("wready_after_free", write_ready_o, 1);
        tick;
        read_ready_i = 1'b1;
        for (int c = 0; c < 200; c++) begin
            tick;
            if (sb.size() == 0 && !read_valid_o) break;
        end
        check_eq("drain2_empty", sb.size(), 0);

        // Continuous writes, random reader stalls, extreme signed values
        for (int i = 0; i < 96; i++) begin
            if (i % 7 == 0)       pat[i] = 32'hFFFF_FFFF;
            else if (i % 11 == 0) pat[i] = 32'h8000_0000;
            else if (i % 13 == 0) pat[i] = 32'h0;
            else                  pat[i] = $urandom;
        end
        acc = 0;
        for (int c = 0; c < 3000 && acc < 96; c++) begin
            read_ready_i  = ($urandom_range(0, 3) != 0);
            write_valid_i = 1'b1;
            write_data_i  = pat[acc];
            @(negedge clk_i);
            if (write_ready_o) acc++;
            tick;
        end
        write_valid_i = 1'b0;
        check_eq("stream_accepted", acc, 96);
        read_ready_i = 1'b1;
        for (int c = 0; c < 300; c++) begin
            tick;
            if (sb.size() == 0 && !read_valid_o) break;
        end
        check_eq("drain3_empty", sb.size(), 0);

        // Reset mid-write (7 words in), then mid-read, then a clean frame
        rst_i = 1'b1; tick; rst_i = 1'b0;
        read_ready_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            write_valid_i = 1'b1;
            write_data_i  = W'(300 + i);
            tick;
        end
        write_valid_i = 1'b0;
        rst_i = 1'b1; tick; rst_i = 1'b0;
        @(negedge clk_i);
        check_eq("rst1_banks", banks_full_o, 0);
        check_eq("rst1_frame", frame_ready_o, 0);
        tick;
        for (int i = 0; i < D; i++) begin
            write_valid_i = 1'b1;
            write_data_i  = W'(400 + i);
            tick;
        end
        write_valid_i = 1'b0;
        read_ready_i  = 1'b1;
        repeat (6) tick;
        rst_i = 1'b1; tick; rst_i = 1'b0;
        @(negedge clk_i);
        check_eq("rst2_valid", read_valid_o, 0);
        check_eq("rst2_banks", banks_full_o, 0);
        tick;
        for (int i = 0; i < D; i++) begin
            write_valid_i = 1'b1;
            write_data_i  = 32'hA0 + W'(i);
            tick;
        end
        write_valid_i = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick;
            if (sb.size() == 0 && !read_valid_o && banks_full_o == 0) break;
        end
        check_eq("drain4_empty", sb.size(), 0);
        check_eq("final_banks", banks_full_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
